// File: rtl/div4_job_sched_if.sv
// Signal bundle between div4_job_sched, its operand producer, the divider and the result consumer.
// The slave modport is the scheduler's view; master is the surrounding environment's view.
interface div4_job_sched_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;

    logic         div_start;
    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic         div_done;
    logic [W-1:0] div_q;
    logic [W-1:0] div_r;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_q;
    logic [W-1:0] out_r;
    logic         out_err;

    modport slave (
        input  in_valid, in_a, in_b, div_done, div_q, div_r, out_ready,
        output in_ready, div_start, div_a, div_b, out_valid, out_q, out_r, out_err
    );

    modport master (
        output in_valid, in_a, in_b, div_done, div_q, div_r, out_ready,
        input  in_ready, div_start, div_a, div_b, out_valid, out_q, out_r, out_err
    );
endinterface

// File: rtl/div4_job_sched.sv
// Job scheduler in front of divide4bit: FIFO of operand pairs, one divide in flight, valid/ready result.
// Build option DIV_ZERO_BYPASS_EN answers b==0 jobs locally without starting the divider.
module div4_job_sched #(
    parameter int W       = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    div4_job_sched_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } job_t;

    state_t        state, state_next;
    job_t          mem [DEPTH];
    job_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    logic          load, cap_done, cap_timeout, bypass, accept;
    logic [CW-1:0] cnt;

    assign full         = (count == (AW+1)'(DEPTH));
    assign empty        = (count == '0);
    assign head         = mem[rd_ptr];
    assign push         = bus.in_valid && !full;
    assign bus.in_ready = !full;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the job storage has no reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next    = state;
        pop           = 1'b0;
        load          = 1'b0;
        cap_done      = 1'b0;
        cap_timeout   = 1'b0;
        bypass        = 1'b0;
        accept        = 1'b0;
        bus.div_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
`ifdef DIV_ZERO_BYPASS_EN
                    if (head.b == '0) begin
                        bypass     = 1'b1;
                        pop        = 1'b1;
                        state_next = HOLD;
                    end else
`endif
                    begin
                        load       = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                bus.div_start = 1'b1;
                state_next    = WAIT;
            end
            WAIT: begin
                // A done in the final allowed cycle still wins over the timeout.
                if (bus.div_done) begin
                    cap_done   = 1'b1;
                    pop        = 1'b1;
                    state_next = HOLD;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    cap_timeout = 1'b1;
                    pop         = 1'b1;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    accept     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.div_a     <= '0;
            bus.div_b     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_q     <= '0;
            bus.out_r     <= '0;
            bus.out_err   <= 1'b0;
            cnt           <= '0;
        end else begin
            if (load) begin
                bus.div_a <= head.a;
                bus.div_b <= head.b;
            end

            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT && !cap_done && !cap_timeout)
                cnt <= cnt + CW'(1);

            if (cap_done) begin
                bus.out_q     <= bus.div_q;
                bus.out_r     <= bus.div_r;
                bus.out_err   <= 1'b0;
                bus.out_valid <= 1'b1;
            end else if (cap_timeout) begin
                bus.out_q     <= '0;
                bus.out_r     <= '0;
                bus.out_err   <= 1'b1;
                bus.out_valid <= 1'b1;
            end else if (bypass) begin
                bus.out_q     <= '1;
                bus.out_r     <= head.a;
                bus.out_err   <= 1'b1;
                bus.out_valid <= 1'b1;
            end else if (accept) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div4_job_sched.sv
// Randomised self-checking bench for div4_job_sched: a queue-based job/result model plus a
// behavioural divider with per-job latency drive the DUT; all outputs are scored at the falling edge.
module tb_div4_job_sched;
    localparam int W       = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;
`ifdef DIV_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div4_job_sched_if #(.W(W)) bus ();

    div4_job_sched #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         lat;
    } job_t;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       err;
    } res_t;

    job_t iss_q[$];
    res_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0, pushed = 0, presented = 0, starts = 0, push_cyc = 0, cur_lat = 0;
    bit in_flight = 0, hold_chk = 0, lat_chk = 0, prev_hold = 0, prev_valid = 0;
    logic [3:0] pq, pr;
    logic       perr;
    // divider model state
    bit         busy = 0, fresh = 0;
    int         left = 0;
    logic [3:0] la, lb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic monitor();
        job_t j;
        res_t e;
        cyc++;
        if (bus.out_valid && !prev_valid) presented++;
        check("in_ready", bus.in_ready, (pushed - presented) < DEPTH);
        if (prev_hold) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_q", bus.out_q, pq);
            check("hold_r", bus.out_r, pr);
            check("hold_err", bus.out_err, perr);
        end
        if (bus.out_valid) hold_chk = 0;
        if (hold_chk && !bus.div_start) begin
            check("div_a_stable", bus.div_a, la);
            check("div_b_stable", bus.div_b, lb);
        end
        if (bus.div_start) begin
            check("start_in_flight", in_flight, 0);
            in_flight = 1;
            starts++;
            if (lat_chk) begin
                check("start_latency", cyc - push_cyc, 2);
                lat_chk = 0;
            end
            if (iss_q.size() == 0) begin
                check("start_unexpected", 1, 0);
            end else begin
                j = iss_q.pop_front();
                check("div_a", bus.div_a, j.a);
                check("div_b", bus.div_b, j.b);
                la = j.a; lb = j.b; left = j.lat;
                busy = 1; fresh = 1; hold_chk = 1;
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            pushed++;
            push_cyc = cyc;
            j.a = bus.in_a; j.b = bus.in_b; j.lat = cur_lat;
            if (BYP && j.b == 0) begin
                e.q = 4'hF; e.r = j.a; e.err = 1'b1;
            end else begin
                iss_q.push_back(j);
                if (j.lat <= TIMEOUT - 1) begin
                    if (j.b == 0) begin e.q = 4'hF; e.r = j.a; end
                    else begin e.q = j.a / j.b; e.r = j.a % j.b; end
                    e.err = 1'b0;
                end else begin
                    e.q = 4'h0; e.r = 4'h0; e.err = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_q", bus.out_q, e.q);
                check("out_r", bus.out_r, e.r);
                check("out_err", bus.out_err, e.err);
            end
            in_flight = 0;
        end
        prev_hold  = bus.out_valid && !bus.out_ready;
        prev_valid = bus.out_valid;
        pq = bus.out_q; pr = bus.out_r; perr = bus.out_err;
    endtask

    task automatic divider_update();
        if (bus.div_done && !fresh) begin
            bus.div_done = 1'b0;
            busy = 0;
        end else begin
            fresh = 0;
            bus.div_done = 1'b0;
            if (busy) begin
                if (left == 0) begin
                    bus.div_done = 1'b1;
                    if (lb == 0) begin bus.div_q = 4'hF; bus.div_r = la; end
                    else begin bus.div_q = la / lb; bus.div_r = la % lb; end
                end else begin
                    left--;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        divider_update();
    endtask

    task automatic push_job(input logic [3:0] a, input logic [3:0] b, input int lat);
        int p0 = pushed;
        int n = 0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; cur_lat = lat;
        while (pushed == p0 && n < 200) begin step(); n++; end
        check("push_accept", pushed - p0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin step(); n++; end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_q"}, bus.out_q, 0);
        check({tag, "_out_r"}, bus.out_r, 0);
        check({tag, "_out_err"}, bus.out_err, 0);
        check({tag, "_div_start"}, bus.div_start, 0);
        check({tag, "_div_a"}, bus.div_a, 0);
        check({tag, "_div_b"}, bus.div_b, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, n, p0, sel;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        bus.div_done = 1'b0; bus.div_q = '0; bus.div_r = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b0;

        // single job with latency measurement
        bus.out_ready = 1'b1;
        lat_chk = 1;
        push_job(4'd10, 4'd3, 6);
        drain(200);
        check("t1_starts", starts, 1);

        // back-to-back jobs, in-order results
        push_job(4'd15, 4'd4, 2);
        push_job(4'd10, 4'd5, 0);
        push_job(4'd9, 4'd2, 4);
        drain(300);
        check("t2_starts", starts, 4);

        // fill the FIFO while the divider never answers in time
        p0 = pushed;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_a = 4'($urandom_range(0, 15));
            bus.in_b = 4'($urandom_range(1, 15));
            cur_lat = TIMEOUT + 8;
            step();
        end
        check("t3_fill_count", pushed - p0, DEPTH);
        check("t3_in_ready_full", bus.in_ready, 0);
        drain(800);

        // consumer back-pressure for 10 cycles
        bus.out_ready = 1'b0;
        push_job(4'd7, 4'd2, 3);
        push_job(4'd13, 4'd3, 1);
        n = 0;
        while (!bus.out_valid && n < 100) begin step(); n++; end
        check("t4_valid", bus.out_valid, 1);
        s = starts;
        repeat (10) step();
        check("t4_no_start", starts, s);
        drain(300);

        // timeout, done on the timeout cycle, late done ignored, divide by zero
        push_job(4'd12, 4'd5, 1000);
        push_job(4'd11, 4'd4, 2);
        drain(300);
        push_job(4'd14, 4'd3, TIMEOUT - 1);
        push_job(4'd8, 4'd3, TIMEOUT);
        push_job(4'd6, 4'd1, 3);
        drain(400);
        s = starts;
        push_job(4'd10, 4'd0, 2);
        drain(200);
        check("t5_zero_starts", starts - s, BYP ? 0 : 1);

        // randomised traffic
        for (int i = 0; i < 500; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_a = 4'($urandom_range(0, 15));
            bus.in_b = 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 9);
            cur_lat = (sel < 7) ? $urandom_range(0, 6) :
                      (sel == 7) ? TIMEOUT - 1 : (sel == 8) ? TIMEOUT : TIMEOUT + 8;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(3000);

        // reset while a job is waiting on the divider
        bus.out_ready = 1'b1;
        s = starts;
        push_job(4'd9, 4'd4, 50);
        push_job(4'd5, 4'd1, 1);
        n = 0;
        while (starts == s && n < 50) begin step(); n++; end
        check("t7_started", starts - s, 1);
        repeat (3) step();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        step();
        exp_q.delete(); iss_q.delete();
        pushed = 0; presented = 0; prev_valid = 0; prev_hold = 0;
        in_flight = 0; hold_chk = 0; busy = 0; fresh = 0; bus.div_done = 1'b0;
        check_reset("rst_mid");
        rst = 1'b0;
        repeat (40) step();
        check("t7_no_restart", starts - s, 1);
        check("t7_no_pulse", bus.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
